// File: rtl/des_pkg.sv
// des_pkg: shared DES definitions for the mode engine.
//   - bit-position tables (IP, FP, E, P, PC1, PC2), 1-based from the MSB
//   - S-boxes flattened as {box[2:0], row[1:0], col[3:0]}
//   - cumulative key-rotate table per round
//   - FSM state enum
//   - des_subkey(key, round) and des_f(r, subkey), plus IP/FP helpers
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } des_state_e;

  localparam logic [6:0] IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam logic [6:0] FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};

  localparam logic [6:0] E_T [48] = '{
    32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};

  localparam logic [6:0] P_T [32] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};

  localparam logic [6:0] PC1_T [56] = '{
    57,49,41,33,25,17, 9,  1,58,50,42,34,26,18, 10, 2,59,51,43,35,27,
    19,11, 3,60,52,44,36, 63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
    14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};

  localparam logic [6:0] PC2_T [48] = '{
    14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // total left-rotation of C/D after round k (1..16), so any round's subkey
  // can be formed directly from the key without walking the schedule
  localparam logic [4:0] ROT_T [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};

  localparam logic [3:0] SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[6'(7'd64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[6'(7'd64 - FP_T[i])];
    return y;
  endfunction

  // round is 0-based (0 -> K1)
  function automatic logic [47:0] des_subkey(input logic [63:0] key, input logic [3:0] round);
    logic [55:0] cd, cc, dd, cd_r;
    logic [47:0] k;
    logic [4:0]  n;
    for (int i = 0; i < 56; i++) cd[55-i] = key[6'(7'd64 - PC1_T[i])];
    n  = ROT_T[round];
    cc = {cd[55:28], cd[55:28]};
    dd = {cd[27:0], cd[27:0]};
    cd_r = {cc[6'(6'd55 - {1'b0, n}) -: 28], dd[6'(6'd55 - {1'b0, n}) -: 28]};
    for (int i = 0; i < 48; i++) k[47-i] = cd_r[6'(7'd56 - PC2_T[i])];
    return k;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] subkey);
    logic [47:0] x;
    logic [31:0] s, o;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) x[47-i] = r[5'(7'd32 - E_T[i])];
    x = x ^ subkey;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = SBOX[{3'(b), six[5], six[0], six[4:1]}];
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[5'(7'd32 - P_T[i])];
    return o;
  endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational Feistel round.
//   i_l, i_r     : current halves
//   i_subkey     : 48-bit round key
//   o_l, o_r     : next halves (o_l = i_r, o_r = i_l ^ f(i_r, i_subkey))
module des_round
  import des_pkg::*;
(
  input  logic [31:0] i_l,
  input  logic [31:0] i_r,
  input  logic [47:0] i_subkey,
  output logic [31:0] o_l,
  output logic [31:0] o_r
);

  assign o_l = i_r;
  assign o_r = i_l ^ des_f(i_r, i_subkey);

endmodule

// File: rtl/des_mode_engine.sv
// des_mode_engine: iterative DES / 3DES-EDE engine, ECB or CBC, one block in
// flight, valid/ready on both sides.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_cleartext, i_key1..3    : block and keys, captured on accept
//   i_encrypt, i_cbc          : direction and chaining mode, captured on accept
//   i_iv, i_iv_load           : chain register load (IDLE only)
//   i_dv / o_ready            : input handshake
//   o_ciphertext, o_dv / i_ready : output handshake
//
// state   | meaning
// IDLE    | waiting for a block, o_ready=1
// RUN     | ROUNDS_PER_CYCLE rounds per clock, pass_q selects key/direction
// DONE    | result held on o_ciphertext with o_dv=1 until i_ready
module des_mode_engine
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TRIPLE           = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_cleartext,
  input  logic [63:0] i_key1,
  input  logic [63:0] i_key2,
  input  logic [63:0] i_key3,
  input  logic        i_encrypt,
  input  logic        i_cbc,
  input  logic [63:0] i_iv,
  input  logic        i_iv_load,
  input  logic        i_dv,
  output logic        o_ready,
  output logic [63:0] o_ciphertext,
  output logic        o_dv,
  input  logic        i_ready
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("des_mode_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int         RPC       = ROUNDS_PER_CYCLE;
  localparam logic [3:0] RND_STEP  = 4'(RPC);
  localparam logic [3:0] LAST_RND  = 4'(16 - RPC);
  localparam logic [1:0] LAST_PASS = (TRIPLE != 0) ? 2'd2 : 2'd0;

  des_state_e  state_q, state_d;
  logic [31:0] l_q, r_q;
  logic [63:0] k1_q, k2_q, k3_q, blk_q, chain_q, ct_q;
  logic        enc_q, cbc_q;
  logic [3:0]  rnd_q;
  logic [1:0]  pass_q;

  logic        last_cyc, last_pass, pass_dec;
  logic [63:0] pass_key, chain_eff, blk_in;

  assign last_cyc  = (rnd_q == LAST_RND);
  assign last_pass = (pass_q == LAST_PASS);

  // EDE: the middle pass runs opposite to the block direction, and the
  // outer keys are taken in reverse order when decrypting
  assign pass_dec = (TRIPLE != 0 && pass_q == 2'd1) ? enc_q : !enc_q;
  assign pass_key = (TRIPLE != 0 && pass_q == 2'd1) ? k2_q :
                    (TRIPLE == 0 || ((pass_q == 2'd0) == enc_q)) ? k1_q : k3_q;

  // a same-cycle IV load applies to the block being accepted
  assign chain_eff = i_iv_load ? i_iv : chain_q;
  assign blk_in    = (i_cbc && i_encrypt) ? (i_cleartext ^ chain_eff) : i_cleartext;

  logic [31:0] l_c [RPC+1];
  logic [31:0] r_c [RPC+1];
  assign l_c[0] = l_q;
  assign r_c[0] = r_q;

  for (genvar j = 0; j < RPC; j++) begin : g_rnd
    logic [3:0]  idx;
    logic [47:0] sk;
    assign idx = rnd_q + 4'(j);
    assign sk  = des_subkey(pass_key, pass_dec ? (4'd15 - idx) : idx);
    des_round u_round (
      .i_l      (l_c[j]),
      .i_r      (r_c[j]),
      .i_subkey (sk),
      .o_l      (l_c[j+1]),
      .o_r      (r_c[j+1])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_dv) state_d = ST_RUN;
      ST_RUN:  if (last_cyc && last_pass) state_d = ST_DONE;
      ST_DONE: if (i_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      l_q <= '0; r_q <= '0;
      k1_q <= '0; k2_q <= '0; k3_q <= '0;
      blk_q <= '0; chain_q <= '0; ct_q <= '0;
      enc_q <= 1'b0; cbc_q <= 1'b0;
      rnd_q <= '0; pass_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_iv_load) chain_q <= i_iv;
          if (i_dv) begin
            k1_q <= i_key1; k2_q <= i_key2; k3_q <= i_key3;
            enc_q <= i_encrypt; cbc_q <= i_cbc;
            blk_q <= i_cleartext;
            {l_q, r_q} <= des_ip(blk_in);
            rnd_q <= '0;
            pass_q <= '0;
          end
        end
        ST_RUN: begin
          if (last_cyc) begin
            rnd_q <= '0;
            if (last_pass) begin
              ct_q <= des_fp({r_c[RPC], l_c[RPC]}) ^ ((cbc_q && !enc_q) ? chain_q : 64'd0);
            end else begin
              // swapped halves feed the next pass directly; FP/IP cancel
              pass_q <= pass_q + 2'd1;
              l_q <= r_c[RPC];
              r_q <= l_c[RPC];
            end
          end else begin
            rnd_q <= rnd_q + RND_STEP;
            l_q <= l_c[RPC];
            r_q <= r_c[RPC];
          end
        end
        ST_DONE: begin
          if (i_ready && cbc_q) chain_q <= enc_q ? ct_q : blk_q;
        end
        default: ;
      endcase
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_dv         = (state_q == ST_DONE);
  assign o_ciphertext = ct_q;

endmodule

// File: tb/tb_des_mode_engine.sv
module tb_des_mode_engine;

  localparam int ND = 7;
  localparam int RPC [ND] = '{1, 2, 4, 8, 16, 1, 4};
  localparam int TRP [ND] = '{0, 0, 0, 0, 0, 1, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] clr [ND], k1 [ND], k2 [ND], k3 [ND], iv [ND], ct [ND];
  logic        enc [ND], cbc [ND], ivld [ND], dv [ND], rdy [ND], ordy [ND], odv [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    des_mode_engine #(.ROUNDS_PER_CYCLE(RPC[g]), .TRIPLE(TRP[g])) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cleartext(clr[g]),
      .i_key1(k1[g]), .i_key2(k2[g]), .i_key3(k3[g]),
      .i_encrypt(enc[g]), .i_cbc(cbc[g]), .i_iv(iv[g]), .i_iv_load(ivld[g]),
      .i_dv(dv[g]), .o_ready(ordy[g]), .o_ciphertext(ct[g]), .o_dv(odv[g]),
      .i_ready(rdy[g]));
  end

  int checks = 0;
  int failures = 0;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model: textbook DES, FP derived from IP ----------------
  localparam int M_IP [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int M_E [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int M_P [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int M_PC1 [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int M_PC2 [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int M_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int M_S [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, o;
    int v, row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-M_E[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      v = int'(x[47-6*b -: 6]);
      row = (v / 32) * 2 + (v % 2);
      col = (v / 2) % 16;
      s[31-4*b -: 4] = 4'(M_S[b*64 + row*16 + col]);
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[32-M_P[i]];
    return o;
  endfunction

  function automatic logic [63:0] m_des(input logic [63:0] blk, input logic [63:0] key, input bit e);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] ks [16];
    logic [63:0] x, y;
    logic [31:0] l, r, t;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-M_PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rr = 0; rr < 16; rr++) begin
      for (int s = 0; s < M_SH[rr]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[rr][47-i] = cd[56-M_PC2[i]];
    end
    for (int i = 0; i < 64; i++) x[63-i] = blk[64-M_IP[i]];
    l = x[63:32];
    r = x[31:0];
    for (int rr = 0; rr < 16; rr++) begin
      t = r;
      r = l ^ m_f(r, e ? ks[rr] : ks[15-rr]);
      l = t;
    end
    x = {r, l};
    for (int i = 0; i < 64; i++) y[64-M_IP[i]] = x[63-i];
    return y;
  endfunction

  function automatic logic [63:0] m_3des(input logic [63:0] blk, input logic [63:0] a,
                                         input logic [63:0] b, input logic [63:0] c, input bit e);
    if (e) return m_des(m_des(m_des(blk, a, 1'b1), b, 1'b0), c, 1'b1);
    return m_des(m_des(m_des(blk, c, 1'b0), b, 1'b1), a, 1'b0);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- one block through DUT d ----------------
  task automatic run_block(input int d, input logic [63:0] blk, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c, input logic e,
                           input logic cb, input logic ld, input logic [63:0] ivv,
                           input int hold, input bit pulse,
                           output logic [63:0] res, output int lat);
    chk64($sformatf("d%0d_ready_idle", d), 64'(ordy[d]), 64'd1);
    clr[d] = blk; k1[d] = a; k2[d] = b; k3[d] = c;
    enc[d] = e; cbc[d] = cb; ivld[d] = ld; iv[d] = ivv;
    dv[d] = 1'b1;
    rdy[d] = (hold == 0);
    @(posedge clk); #1;
    // scramble everything after accept: the DUT must work from captured copies
    ivld[d] = 1'b0; clr[d] = ~blk; k1[d] = ~a; k2[d] = ~b; k3[d] = ~c;
    enc[d] = ~e; cbc[d] = ~cb; iv[d] = ~ivv;
    dv[d] = 1'b0;
    for (lat = 1; lat <= 200; lat++) begin
      dv[d] = pulse & lat[0];
      @(posedge clk); #1;
      if (odv[d]) break;
      if (pulse) chk64($sformatf("d%0d_ready_in_run", d), 64'(ordy[d]), 64'd0);
    end
    dv[d] = 1'b0;
    res = ct[d];
    chk64($sformatf("d%0d_dv_in_budget", d), 64'(odv[d]), 64'd1);
    if (odv[d]) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk64("stall_ct", ct[d], res);
        chk64("stall_dv", 64'(odv[d]), 64'd1);
        chk64("stall_ready", 64'(ordy[d]), 64'd0);
      end
      rdy[d] = 1'b1;
      @(posedge clk); #1;
      chk64($sformatf("d%0d_dv_after_hs", d), 64'(odv[d]), 64'd0);
      chk64($sformatf("d%0d_ready_after_hs", d), 64'(ordy[d]), 64'd1);
    end
  endtask

  typedef struct {
    int          d;
    logic [63:0] blk;
    logic [63:0] key;
    bit          e;
    logic [63:0] exp_ct;
    int          exp_lat;
  } vec_t;

  localparam logic [63:0] KA = 64'h133457799BBCDFF1;
  localparam logic [63:0] PA = 64'h0123456789ABCDEF;
  localparam logic [63:0] CA = 64'h85E813540F0AB405;
  localparam logic [63:0] KB = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PB = 64'h8787878787878787;

  vec_t vt [10];

  initial begin
    logic [63:0] res, c1, c2, p2, p3, x, blk, a, b, c, e3, exp, chain_m, ivv;
    int lat;
    bit e, cb, ld;

    for (int d = 0; d < ND; d++) begin
      clr[d] = '0; k1[d] = '0; k2[d] = '0; k3[d] = '0; iv[d] = '0;
      enc[d] = 1'b0; cbc[d] = 1'b0; ivld[d] = 1'b0; dv[d] = 1'b1; rdy[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk64($sformatf("d%0d_rst_ready", d), 64'(ordy[d]), 64'd1);
      chk64($sformatf("d%0d_rst_dv", d), 64'(odv[d]), 64'd0);
      chk64($sformatf("d%0d_rst_ct", d), ct[d], 64'd0);
      dv[d] = 1'b0;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    vt[0] = '{d:0, blk:PA, key:KA, e:1'b1, exp_ct:CA, exp_lat:16};
    vt[1] = '{d:0, blk:CA, key:KA, e:1'b0, exp_ct:PA, exp_lat:16};
    vt[2] = '{d:0, blk:PB, key:KB, e:1'b1, exp_ct:64'd0, exp_lat:16};
    vt[3] = '{d:1, blk:PB, key:KB, e:1'b1, exp_ct:64'd0, exp_lat:8};
    vt[4] = '{d:2, blk:PB, key:KB, e:1'b1, exp_ct:64'd0, exp_lat:4};
    vt[5] = '{d:3, blk:PB, key:KB, e:1'b1, exp_ct:64'd0, exp_lat:2};
    vt[6] = '{d:4, blk:PB, key:KB, e:1'b1, exp_ct:64'd0, exp_lat:1};
    vt[7] = '{d:5, blk:PA, key:KA, e:1'b1, exp_ct:CA, exp_lat:48};
    vt[8] = '{d:6, blk:PA, key:KA, e:1'b1, exp_ct:CA, exp_lat:12};
    vt[9] = '{d:5, blk:CA, key:KA, e:1'b0, exp_ct:PA, exp_lat:48};

    for (int i = 0; i < 10; i++) begin
      if (TRP[vt[i].d] != 0) begin b = vt[i].key; c = vt[i].key; end
      else begin b = rand64(); c = rand64(); end
      run_block(vt[i].d, vt[i].blk, vt[i].key, b, c, vt[i].e, 1'b0, 1'b0, 64'd0, 0, 1'b0, res, lat);
      chk64($sformatf("vec%0d_ct", i), res, vt[i].exp_ct);
      chk64($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
    end

    // CBC chaining, ECB transparency to the chain, CBC decrypt, same-cycle IV load
    p2 = rand64(); p3 = rand64(); x = rand64();
    run_block(0, PA, KA, 0, 0, 1'b1, 1'b1, 1'b1, 64'd0, 0, 1'b0, c1, lat);
    chk64("cbc_c1_equals_ecb", c1, CA);
    run_block(0, p3, KA, 0, 0, 1'b1, 1'b0, 1'b0, 64'd0, 0, 1'b0, res, lat);
    chk64("ecb_between_cbc", res, m_des(p3, KA, 1'b1));
    run_block(0, p2, KA, 0, 0, 1'b1, 1'b1, 1'b0, 64'd0, 0, 1'b0, c2, lat);
    chk64("cbc_c2", c2, m_des(p2 ^ CA, KA, 1'b1));
    run_block(0, CA, KA, 0, 0, 1'b0, 1'b1, 1'b1, 64'd0, 0, 1'b0, res, lat);
    chk64("cbc_dec_p1", res, PA);
    run_block(0, m_des(p2 ^ CA, KA, 1'b1), KA, 0, 0, 1'b0, 1'b1, 1'b0, 64'd0, 0, 1'b0, res, lat);
    chk64("cbc_dec_p2", res, p2);
    run_block(0, PA, KA, 0, 0, 1'b1, 1'b1, 1'b1, x, 0, 1'b0, res, lat);
    chk64("cbc_iv_load_with_accept", res, m_des(PA ^ x, KA, 1'b1));

    // backpressure and ignored i_dv pulses during RUN
    run_block(0, PA, KA, 0, 0, 1'b1, 1'b0, 1'b0, 64'd0, 20, 1'b0, res, lat);
    chk64("stall_result", res, CA);
    run_block(0, CA, KA, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 0, 1'b1, res, lat);
    chk64("pulse_result", res, PA);
    chk64("pulse_latency", 64'(lat), 64'd16);

    // random single-DES traffic, mixed ECB/CBC, with a chain model
    chain_m = '0;
    for (int i = 0; i < 100; i++) begin
      blk = rand64(); a = rand64(); ivv = rand64();
      e = 1'($urandom_range(0, 1));
      cb = 1'($urandom_range(0, 1));
      ld = (i == 0) || ($urandom_range(0, 7) == 0);
      if (ld) chain_m = ivv;
      if (!cb) exp = m_des(blk, a, e);
      else if (e) begin exp = m_des(blk ^ chain_m, a, 1'b1); chain_m = exp; end
      else begin exp = m_des(blk, a, 1'b0) ^ chain_m; chain_m = blk; end
      run_block(0, blk, a, rand64(), rand64(), e, cb, ld, ivv, 0, 1'b0, res, lat);
      chk64($sformatf("rand_des_%0d", i), res, exp);
    end

    // random 3DES round trips with distinct keys
    for (int i = 0; i < 1000; i++) begin
      blk = rand64(); a = rand64(); b = rand64(); c = rand64();
      e3 = m_3des(blk, a, b, c, 1'b1);
      run_block(6, blk, a, b, c, 1'b1, 1'b0, 1'b0, 64'd0, 0, 1'b0, res, lat);
      chk64($sformatf("rand_3des_enc_%0d", i), res, e3);
      run_block(6, e3, a, b, c, 1'b0, 1'b0, 1'b0, 64'd0, 0, 1'b0, res, lat);
      chk64($sformatf("rand_3des_dec_%0d", i), res, blk);
    end

    // reset 5 cycles into RUN of a CBC block that loaded a nonzero IV
    x = rand64() | 64'h1;
    clr[0] = PA; k1[0] = KA; enc[0] = 1'b1; cbc[0] = 1'b1; ivld[0] = 1'b1; iv[0] = x;
    dv[0] = 1'b1;
    @(posedge clk); #1;
    dv[0] = 1'b0; ivld[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk64("pre_reset_dv", 64'(odv[0]), 64'd0);
    chk64("pre_reset_ct_nonzero", 64'(ct[0] != 64'd0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk64("mid_reset_ready", 64'(ordy[0]), 64'd1);
    chk64("mid_reset_dv", 64'(odv[0]), 64'd0);
    chk64("mid_reset_ct", ct[0], 64'd0);
    dv[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk64("in_reset_dv", 64'(odv[0]), 64'd0);
      chk64("in_reset_ready", 64'(ordy[0]), 64'd1);
    end
    dv[0] = 1'b0;
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk64("post_reset_no_dv", 64'(odv[0]), 64'd0);
    end
    run_block(0, PA, KA, 0, 0, 1'b1, 1'b1, 1'b0, 64'd0, 0, 1'b0, res, lat);
    chk64("post_reset_cbc_chain_zero", res, CA);
    chk64("post_reset_latency", 64'(lat), 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
